monitor_sched: RTL and testbench
================================

# monitor_sched

Round-robin scheduler that time-shares a single temperature `monitor` instance between `CHANNELS` BCD temperature sources. For each granted channel it replays that channel's previous sample into the monitor, then the new sample, waits for the monitor to settle, and captures the resulting delta and state. The delta is tagged with the channel number. It sits between the sensor front-ends and the monitor, and owns the monitor's `en`, `mode` and value inputs.

## Interface
- `CHANNELS`, default 4: number of requesting sources, from 2 to 8.
- `SETTLE`, default 3: idle cycles after the second load before capture, at least 1.
- `CW`, default `$clog2(CHANNELS)`: channel index width.

- `clk` in 1: single clock; all logic is rising-edge.
- `rst` in 1: asynchronous, active-low reset.
- `run` in 1: when high, new grants are allowed.
- `mode` in 1: monitor mode, latched at grant.
- `req` in CHANNELS: level request per channel.
- `ch_temp` in 13*CHANNELS: per channel `{sign, huns[3:0], tens[3:0], ones[3:0]}`, with channel 0 in the LSBs.
- `gnt` out CHANNELS: one-hot grant, one-cycle pulse.
- `busy` out 1: high whenever the FSM is not in IDLE.
- `mon_en`, `mon_mode` out 1, 1: drive the monitor's `en` and `mode`.
- `mon_value_{ones,tens,huns}` out 4 each; `mon_value_sign` out 1: drive the monitor's value inputs.
- `mon_delta_{ones,tens,huns}` in 4 each; `mon_delta_sign` in 1; `mon_state` in 4: monitor outputs.
- `res_valid` out 1: one-cycle result strobe.
- `res_ch` out CW: channel index of the result.
- `res_delta` out 13: `{sign, huns, tens, ones}` of the captured delta.
- `res_state` out 4: captured `mon_state`.
- `alarm` out CHANNELS: sticky per-channel alarm (see Configuration).
- `alarm_clr` in CHANNELS: per-channel alarm clear.

## Operation
- FSM states: IDLE, LOAD_PREV, LOAD_CUR, SETTLE, CAPTURE.
- **IDLE**
  - If `run && |req`, pick the first requesting channel searching upward from `last+1`, wrapping modulo CHANNELS.
  - In the same cycle, pulse `gnt` for that channel.
  - Latch `cur <= ch_temp[ch]`, `ch`, and `mode`.
  - Go to LOAD_PREV.
- **LOAD_PREV** (1 cycle)
  - `mon_en=1`.
  - Drive `mon_value` with `prev[ch]` if `pv[ch]` is set; otherwise drive `cur`, so the first delta after reset is 0.
- **LOAD_CUR** (1 cycle): `mon_en=1`, `mon_value=cur`.
- **SETTLE** (`SETTLE` cycles, down-counter): `mon_en=0`, `mon_value` held at `cur`.
- **CAPTURE** (1 cycle)
  - `res_valid=1`.
  - Register `res_delta`/`res_state` from the monitor outputs.
  - Update `prev[ch] <= cur`, `pv[ch] <= 1`, `last <= ch`.
  - Return to IDLE.
- `res_ch`, `res_delta` and `res_state` hold their value until the next CAPTURE.
- `mon_mode` is the latched mode and is stable for the whole transaction.
- `run` falling mid-transaction: the current transaction completes; no further grants are issued.
- `req` is level-sensitive. A requester keeps `req` high until it sees `gnt`. If `req` is still high after the transaction, that counts as a new request.
- `ch_temp` is sampled only at grant. Later changes do not affect the transaction in flight.
- Reset values:
  - FSM in IDLE, `last = CHANNELS-1` so the first grant goes to channel 0.
  - `pv`, `gnt`, `busy`, `mon_en` and `res_valid` are 0.
  - All `mon_value`, `res_*` and `alarm` outputs are 0; `mon_mode` is 0.
- Reset asserted mid-transaction aborts it. No `res_valid` is issued, and all previous-sample history is discarded.

## Timing
- Grant in cycle N → `mon_en` high in N+1 and N+2 → `res_valid` in N+3+SETTLE.
- Back-to-back grants: the next `gnt` can be issued in the cycle after CAPTURE. Throughput is one result per 4+SETTLE cycles.
- Outputs are registered, except `gnt`, which is the combinational decode of the IDLE-state arbiter and lasts one cycle.
- The monitor must produce a valid delta within `SETTLE` cycles of its second `en`.

## Configuration
- `MONITOR_SCHED_ALARM_EN` defined:
  - In CAPTURE, `alarm[ch]` is set if the captured delta has `huns != 0 || tens != 0` (|delta| ≥ 10).
  - `alarm_clr[i]` clears `alarm[i]` synchronously.
  - If set and clear fall in the same cycle on the same bit, the set wins.
- Not defined: `alarm` is tied to 0 and `alarm_clr` is ignored. The ports remain present.

## Test plan
- Reset, then `run=1`, `req=4'b0001`, ch0 = +025 → `gnt=0001` at N, `mon_en` high at N+1 and N+2, `res_valid` at N+6 with `res_ch=0`, `res_delta=+000`.
- Second request on ch0 with value +037 → `mon_value` shows 025 then 037, `res_delta=+012`. With the alarm macro enabled, `alarm[0]=1`; pulsing `alarm_clr[0]` then clears it.
- `req=4'b1111` held for 8 transactions → grant order 0,1,2,3,0,1,2,3; each `res_ch` matches its grant; no overlap between transactions.
- Ch2 previous = +050 and new = -010 → `res_delta` reflects a 60-degree decrease (`sign=1`, tens=6), `res_state` equals the monitor's state at CAPTURE.
- Drop `run` during SETTLE with `req` still high → current `res_valid` is still issued; no `gnt` afterwards until `run` returns high.
- Assert `rst` low during LOAD_CUR → outputs return to reset values immediately, no `res_valid`. The next ch0 transaction yields delta 0 because its history was cleared.

Source files
------------

// File: rtl/monitor_sched.sv
// Round-robin scheduler time-sharing one temperature monitor across channels.
// Define MONITOR_SCHED_ALARM_EN for sticky per-channel |delta|>=10 alarms.
module monitor_sched #(
  parameter int CHANNELS = 4,
  parameter int SETTLE   = 3,
  parameter int CW       = $clog2(CHANNELS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   run,
  input  logic                   mode,
  input  logic [CHANNELS-1:0]    req,
  input  logic [13*CHANNELS-1:0] ch_temp,
  output logic [CHANNELS-1:0]    gnt,
  output logic                   busy,
  output logic                   mon_en,
  output logic                   mon_mode,
  output logic [3:0]             mon_value_ones,
  output logic [3:0]             mon_value_tens,
  output logic [3:0]             mon_value_huns,
  output logic                   mon_value_sign,
  input  logic [3:0]             mon_delta_ones,
  input  logic [3:0]             mon_delta_tens,
  input  logic [3:0]             mon_delta_huns,
  input  logic                   mon_delta_sign,
  input  logic [3:0]             mon_state,
  output logic                   res_valid,
  output logic [CW-1:0]          res_ch,
  output logic [12:0]            res_delta,
  output logic [3:0]             res_state,
  output logic [CHANNELS-1:0]    alarm,
  input  logic [CHANNELS-1:0]    alarm_clr
);

  localparam int SW = (SETTLE < 2) ? 1 : $clog2(SETTLE);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_PREV,
    S_LOAD_CUR,
    S_SETTLE,
    S_CAPTURE
  } state_t;

  state_t              state_q, state_d;
  logic [SW-1:0]       cnt_q, cnt_d;
  logic [CW-1:0]       ch_q, ch_d;
  logic [CW-1:0]       last_q, last_d;
  logic [12:0]         cur_q, cur_d;
  logic [12:0]         val_q, val_d;
  logic                mode_q, mode_d;
  logic                en_q, en_d;
  logic                rv_q, rv_d;
  logic [CW-1:0]       rch_q, rch_d;
  logic [12:0]         rd_q, rd_d;
  logic [3:0]          rs_q, rs_d;
  logic [12:0]         prev_q [CHANNELS];
  logic [12:0]         prev_d [CHANNELS];
  logic [CHANNELS-1:0] pv_q, pv_d;
  logic [CHANNELS-1:0] al_q, al_d;

  logic                found;
  logic                grant;
  logic [CW-1:0]       idx;
  logic [CW-1:0]       sel;
  logic [12:0]         sel_temp;
  logic [12:0]         delta_in;

  assign delta_in = {mon_delta_sign, mon_delta_huns,
                     mon_delta_tens, mon_delta_ones};

`ifdef MONITOR_SCHED_ALARM_EN
  logic alarm_hit;
  assign alarm_hit = (mon_delta_huns != 4'd0) ||
                     (mon_delta_tens != 4'd0);
`else
  logic unused_clr;
  assign unused_clr = ^alarm_clr;
`endif

  // First requester strictly after the last served channel, wrapping.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    idx   = '0;
    for (int i = 1; i <= CHANNELS; i++) begin
      idx = CW'((int'(last_q) + i) % CHANNELS);
      if (!found && req[idx]) begin
        found = 1'b1;
        sel   = idx;
      end
    end
  end

  assign sel_temp = ch_temp[13*sel +: 13];
  assign grant    = rst && run && found && (state_q == S_IDLE);
  assign gnt      = grant ? (CHANNELS'(1) << sel) : '0;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ch_d    = ch_q;
    last_d  = last_q;
    cur_d   = cur_q;
    val_d   = val_q;
    mode_d  = mode_q;
    en_d    = en_q;
    rv_d    = 1'b0;
    rch_d   = rch_q;
    rd_d    = rd_q;
    rs_d    = rs_q;
    pv_d    = pv_q;
    prev_d  = prev_q;
`ifdef MONITOR_SCHED_ALARM_EN
    al_d    = al_q & ~alarm_clr;
`else
    al_d    = '0;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (grant) begin
          state_d = S_LOAD_PREV;
          ch_d    = sel;
          cur_d   = sel_temp;
          mode_d  = mode;
          en_d    = 1'b1;
          // No history yet: replay the new sample so the delta is zero.
          val_d   = pv_q[sel] ? prev_q[sel] : sel_temp;
        end
      end
      S_LOAD_PREV: begin
        state_d = S_LOAD_CUR;
        en_d    = 1'b1;
        val_d   = cur_q;
      end
      S_LOAD_CUR: begin
        state_d = S_SETTLE;
        en_d    = 1'b0;
        cnt_d   = SW'(SETTLE - 1);
      end
      S_SETTLE: begin
        if (cnt_q == '0) begin
          state_d      = S_CAPTURE;
          rv_d         = 1'b1;
          rch_d        = ch_q;
          rd_d         = delta_in;
          rs_d         = mon_state;
          prev_d[ch_q] = cur_q;
          pv_d[ch_q]   = 1'b1;
          last_d       = ch_q;
`ifdef MONITOR_SCHED_ALARM_EN
          if (alarm_hit) al_d[ch_q] = 1'b1;
`endif
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_CAPTURE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ch_q    <= '0;
      last_q  <= CW'(CHANNELS - 1);
      cur_q   <= '0;
      val_q   <= '0;
      mode_q  <= 1'b0;
      en_q    <= 1'b0;
      rv_q    <= 1'b0;
      rch_q   <= '0;
      rd_q    <= '0;
      rs_q    <= '0;
      pv_q    <= '0;
      al_q    <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        prev_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ch_q    <= ch_d;
      last_q  <= last_d;
      cur_q   <= cur_d;
      val_q   <= val_d;
      mode_q  <= mode_d;
      en_q    <= en_d;
      rv_q    <= rv_d;
      rch_q   <= rch_d;
      rd_q    <= rd_d;
      rs_q    <= rs_d;
      pv_q    <= pv_d;
      al_q    <= al_d;
      prev_q  <= prev_d;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign mon_en    = en_q;
  assign mon_mode  = mode_q;
  assign {mon_value_sign, mon_value_huns,
          mon_value_tens, mon_value_ones} = val_q;
  assign res_valid = rv_q;
  assign res_ch    = rch_q;
  assign res_delta = rd_q;
  assign res_state = rs_q;
  assign alarm     = al_q;

endmodule

// File: tb/tb_monitor_sched.sv
// Bench for monitor_sched: directed table, corner sequences and random
// traffic against a channel-history reference model and a behavioural monitor.
module tb_monitor_sched;

  localparam int N = 4;
  localparam int S = 3;

  logic          clk;
  logic          rst;
  logic          run;
  logic          mode;
  logic [N-1:0]  req;
  logic [13*N-1:0] ch_temp;
  logic [N-1:0]  gnt;
  logic          busy;
  logic          mon_en;
  logic          mon_mode;
  logic [3:0]    mon_value_ones, mon_value_tens, mon_value_huns;
  logic          mon_value_sign;
  logic [3:0]    mon_delta_ones, mon_delta_tens, mon_delta_huns;
  logic          mon_delta_sign;
  logic [3:0]    mon_state;
  logic          res_valid;
  logic [1:0]    res_ch;
  logic [12:0]   res_delta;
  logic [3:0]    res_state;
  logic [N-1:0]  alarm;
  logic [N-1:0]  alarm_clr;

  monitor_sched #(.CHANNELS(N), .SETTLE(S)) dut (
    .clk(clk), .rst(rst), .run(run), .mode(mode), .req(req),
    .ch_temp(ch_temp), .gnt(gnt), .busy(busy),
    .mon_en(mon_en), .mon_mode(mon_mode),
    .mon_value_ones(mon_value_ones), .mon_value_tens(mon_value_tens),
    .mon_value_huns(mon_value_huns), .mon_value_sign(mon_value_sign),
    .mon_delta_ones(mon_delta_ones), .mon_delta_tens(mon_delta_tens),
    .mon_delta_huns(mon_delta_huns), .mon_delta_sign(mon_delta_sign),
    .mon_state(mon_state), .res_valid(res_valid), .res_ch(res_ch),
    .res_delta(res_delta), .res_state(res_state),
    .alarm(alarm), .alarm_clr(alarm_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [12:0] to_bcd(input int v);
    int a;
    a = (v < 0) ? -v : v;
    return {v < 0, 4'(a / 100), 4'((a / 10) % 10), 4'(a % 10)};
  endfunction

  function automatic int from_bcd(input logic [12:0] b);
    int m;
    m = int'(b[11:8]) * 100 + int'(b[7:4]) * 10 + int'(b[3:0]);
    return b[12] ? -m : m;
  endfunction

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic logic [3:0] st_of(input bit md, input int d);
    return {md, d < 0, iabs(d) >= 10, iabs(d) >= 100};
  endfunction

  // Behavioural monitor: delta between the last two loaded samples.
  int mon_p, mon_c, mon_d;
  logic [12:0] mon_val;
  assign mon_val = {mon_value_sign, mon_value_huns,
                    mon_value_tens, mon_value_ones};
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mon_p <= 0;
      mon_c <= 0;
    end else if (mon_en) begin
      mon_p <= mon_c;
      mon_c <= from_bcd(mon_val);
    end
  end
  assign mon_d = mon_c - mon_p;
  assign {mon_delta_sign, mon_delta_huns,
          mon_delta_tens, mon_delta_ones} = to_bcd(mon_d);
  assign mon_state = st_of(mon_mode, mon_d);

  // Reference model state
  int         temps [N];
  int         m_prev [N];
  bit [N-1:0] m_pv;
  int         m_last;
  logic [N-1:0] m_alarm;

  int n_pass, n_total;

  task automatic chk(input string nm, input int got, input int exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
  endtask

  task automatic fail(input string nm);
    n_total++;
    $display("FAIL %s: got timeout, expected event", nm);
  endtask

  task automatic apply_temps();
    for (int i = 0; i < N; i++) ch_temp[13*i +: 13] = to_bcd(temps[i]);
  endtask

  task automatic scramble();
    for (int i = 0; i < N; i++) temps[i] = int'($urandom_range(998)) - 499;
    apply_temps();
    mode = 1'($urandom);
  endtask

  task automatic model_reset();
    m_last  = N - 1;
    m_pv    = '0;
    m_alarm = '0;
    for (int i = 0; i < N; i++) m_prev[i] = 0;
  endtask

  function automatic int pick(input logic [N-1:0] r);
    for (int i = 1; i <= N; i++)
      if (r[(m_last + i) % N]) return (m_last + i) % N;
    return -1;
  endfunction

  function automatic int exp_delta(input int e, input int cur);
    return m_pv[e] ? cur - m_prev[e] : 0;
  endfunction

  task automatic commit(input int e, input int cur, input int d);
    m_prev[e] = cur;
    m_pv[e]   = 1'b1;
    m_last    = e;
`ifdef MONITOR_SCHED_ALARM_EN
    if (iabs(d) >= 10) m_alarm[e] = 1'b1;
`else
    if (d > 9999) m_alarm[e] = 1'b0;
`endif
  endtask

  task automatic chk_reset(input string nm);
    chk({nm, "_gnt"}, gnt, 0);
    chk({nm, "_ctl"}, {busy, mon_en, res_valid, mon_mode}, 0);
    chk({nm, "_val"}, mon_val, 0);
    chk({nm, "_res"}, {res_ch, res_delta, res_state}, 0);
    chk({nm, "_alarm"}, alarm, 0);
  endtask

  task automatic wait_gnt(output int w, output bit ok);
    w = 0;
    #1;
    while (gnt == '0 && w < 40) begin
      @(negedge clk);
      #1;
      w++;
    end
    ok = (gnt != '0);
  endtask

  task automatic do_txn(input logic [N-1:0] r, input bit keep,
                        output int gch, output int gd, output int gw);
    int e, cur, expd, expv;
    bit md, ok;
    req = r;
    gch = -1;
    gd  = 0;
    wait_gnt(gw, ok);
    if (!ok) begin
      fail("gnt_wait");
      return;
    end
    e = pick(r);
    chk("gnt", gnt, 1 << e);
    if (e < 0) return;
    cur  = temps[e];
    md   = mode;
    expv = m_pv[e] ? m_prev[e] : cur;
    expd = exp_delta(e, cur);
    @(negedge clk);
    chk("en_prev", mon_en, 1);
    chk("val_prev", from_bcd(mon_val), expv);
    chk("mon_mode", mon_mode, md);
    chk("busy", busy, 1);
    if (!keep) req = '0;
    scramble();
    @(negedge clk);
    chk("en_cur", mon_en, 1);
    chk("val_cur", from_bcd(mon_val), cur);
    repeat (S) begin
      @(negedge clk);
      chk("settle_quiet", {mon_en, res_valid}, 0);
    end
    @(negedge clk);
    chk("res_valid", res_valid, 1);
    chk("res_ch", res_ch, e);
    chk("res_delta", res_delta, to_bcd(expd));
    chk("res_state", res_state, st_of(md, expd));
    commit(e, cur, expd);
    chk("alarm", alarm, m_alarm);
    gch = e;
    gd  = from_bcd(res_delta);
  endtask

  typedef struct {
    logic [N-1:0] rq;
    int           tch;
    int           temp;
    bit           md;
    int           ech;
    int           ed;
  } vec_t;

  vec_t tbl [9];

  initial begin
    int gch, gd, gw, cur, expd, w;
    bit ok, md;
    n_pass = 0;
    n_total = 0;
    tbl[0] = '{4'b0001, 0,   25, 1'b0, 0,   0};
    tbl[1] = '{4'b0001, 0,   37, 1'b1, 0,  12};
    tbl[2] = '{4'b0100, 2,   50, 1'b0, 2,   0};
    tbl[3] = '{4'b0100, 2,  -10, 1'b1, 2, -60};
    tbl[4] = '{4'b0010, 1,    7, 1'b0, 1,   0};
    tbl[5] = '{4'b1000, 3, -499, 1'b0, 3,   0};
    tbl[6] = '{4'b1010, 1,   -3, 1'b1, 1, -10};
    tbl[7] = '{4'b1010, 3,  499, 1'b0, 3, 998};
    tbl[8] = '{4'b1001, 0,    0, 1'b1, 0, -37};

    rst = 1'b0;
    run = 1'b0;
    mode = 1'b0;
    req = '0;
    alarm_clr = '0;
    for (int i = 0; i < N; i++) temps[i] = 0;
    apply_temps();
    model_reset();
    repeat (3) @(negedge clk);
    chk_reset("por");
    rst = 1'b1;
    run = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 9; i++) begin
      temps[tbl[i].tch] = tbl[i].temp;
      apply_temps();
      mode = tbl[i].md;
      do_txn(tbl[i].rq, 1'b0, gch, gd, gw);
      chk("tbl_ch", gch, tbl[i].ech);
      chk("tbl_delta", gd, tbl[i].ed);
    end

    @(negedge clk);
    alarm_clr = 4'b0001;
    @(negedge clk);
    alarm_clr = '0;
`ifdef MONITOR_SCHED_ALARM_EN
    m_alarm[0] = 1'b0;
`endif
    chk("alarm_clr", alarm, m_alarm);

    rst = 1'b0;
    req = '0;
    model_reset();
    #1;
    chk_reset("rst2");
    @(negedge clk);
    rst = 1'b1;

    for (int k = 0; k < 8; k++) begin
      do_txn(4'b1111, 1'b1, gch, gd, gw);
      chk("rr_order", gch, k % N);
      if (k > 0) chk("b2b_gap", gw, 1);
    end
    req = '0;

    req = 4'b0001;
    wait_gnt(w, ok);
    if (!ok) fail("rundrop_gnt");
    chk("rundrop_gnt", gnt, 1 << pick(req));
    cur  = temps[0];
    md   = mode;
    expd = exp_delta(0, cur);
    repeat (3) @(negedge clk);
    run = 1'b0;
    w = 0;
    while (!res_valid && w < 10) begin
      @(negedge clk);
      w++;
    end
    chk("rundrop_res", res_valid, 1);
    chk("rundrop_ch", res_ch, 0);
    chk("rundrop_delta", res_delta, to_bcd(expd));
    chk("rundrop_state", res_state, st_of(md, expd));
    commit(0, cur, expd);
    repeat (6) begin
      @(negedge clk);
      chk("rundrop_idle", {gnt, busy}, 0);
    end
    run = 1'b1;
    do_txn(4'b0001, 1'b0, gch, gd, gw);
    chk("regrant_now", gw, 0);

    req = 4'b0001;
    wait_gnt(w, ok);
    if (!ok) fail("midrst_gnt");
    @(negedge clk);
    @(negedge clk);
    chk("midrst_loadcur", mon_en, 1);
    rst = 1'b0;
    model_reset();
    #1;
    chk_reset("midrst");
    repeat (3) begin
      @(negedge clk);
      chk("midrst_novalid", res_valid, 0);
    end
    rst = 1'b1;
    do_txn(4'b0001, 1'b0, gch, gd, gw);
    chk("postrst_ch", gch, 0);
    chk("postrst_delta", gd, 0);

    repeat (40) begin
      do_txn(4'($urandom_range(15, 1)), 1'b0, gch, gd, gw);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
